sum_accumulator_with_flow_control: RTL and testbench
====================================================

Name: sum_accumulator_with_flow_control

Overview:
- Downstream consumer of the adder's sum stream.
- Accepts sums over a valid/ready handshake and adds up groups of `n` consecutive sums.
- Emits one group total per `n` accepted sums on a valid/ready output.
- Double-buffered (running accumulator plus held result register): full throughput when the output is ready; stalls only when a group completes while the previous total is still unaccepted.

Parameters:
- width, 8, operand width of the adder; the input sum is width+1 bits.
- n, 4, number of sums per group; legal range 1..256.
- acc_width, width + 1 + $clog2(n), width of the accumulator and of the output total.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset; synchronous, active-high.
- sum_vld  input  1  upstream sum valid.
- sum_rdy  output  1  upstream ready; a transfer occurs when sum_vld & sum_rdy.
- sum_data  input  width+1  upstream sum value, unsigned.
- acc_vld  output  1  group total valid.
- acc_rdy  input  1  downstream ready; a transfer occurs when acc_vld & acc_rdy.
- acc_data  output  acc_width  group total, unsigned.
- acc_cnt  output  $clog2(n)+1  number of sums accepted into the group in progress (0..n-1), for debug.

Behaviour:
- Clock and reset: one clock `clk`; reset `rst` is synchronous and active-high.
- Reset values: acc register = 0, cnt = 0, result register = 0, acc_vld = 0, acc_cnt = 0. sum_rdy evaluates to 1 after reset.
- State:
  - running accumulator `acc` (acc_width bits);
  - counter `cnt` (0..n-1);
  - result register plus a valid flag (drives acc_data / acc_vld).
- Group completion: `last = (cnt == n-1)`.
- Ready:
  - sum_rdy = ~(acc_vld & ~acc_rdy & last).
  - This is the only combinational path, acc_rdy -> sum_rdy; no path from sum_vld to sum_rdy.
- Input transfer, not last: acc <= acc + zero-extended sum_data; cnt <= cnt + 1.
- Input transfer, last:
  - result <= acc + sum_data; acc_vld <= 1;
  - acc <= 0; cnt <= 0.
- Output transfer with no simultaneous completing input: acc_vld <= 0.
- Simultaneous output transfer and completing input: new total loaded, acc_vld stays 1. Gives back-to-back totals every n cycles.
- Latency: the total appears on acc_data the cycle after the n-th sum is accepted.
- Output stability: while acc_vld & ~acc_rdy, acc_data is held constant. Partial accumulation continues for the first n-1 sums of the next group.
- n = 1: every accepted sum is output one cycle later, zero-extended; behaves as a single-entry register slice.
- Overflow: impossible with the default acc_width. If acc_width is overridden smaller, the macro below defines the behaviour.
- Reset mid-group: the partial sum and a pending total are discarded; no output is produced for them.

Optional Feature:
- Macro: ACCUM_SATURATE_EN.
- Defined:
  - each addition is computed at acc_width+1 bits;
  - if the carry-out is set, the accumulator / result clamps to all-ones;
  - clamping is sticky for the remainder of that group.
- Not defined: additions wrap modulo 2^acc_width.
- With the default acc_width, both modes are cycle- and value-identical.

Test Plan:
- Basic group (width=8, n=4, acc_rdy=1): sums 1,2,3,4 on consecutive cycles -> acc_vld one cycle after the 4th transfer with acc_data=10, asserted for exactly 1 cycle.
- Back-to-back: 8 continuous sums of 510 with acc_rdy=1 -> two totals of 2040, 4 cycles apart; sum_rdy never deasserts.
- Output stall: acc_rdy=0 after the first total 10, continuous input 5s:
  - sum_rdy stays 1 for 3 more transfers;
  - sum_rdy drops on the 4th (last);
  - acc_data holds 10;
  - raising acc_rdy gives the 10 transfer and the 4th input in the same cycle, then next total 20.
- Bubbles: sums 7, idle, 7, idle idle, 7, 7 -> a single total 28; acc_cnt shows 0,1,1,2,2,2,3,0.
- n=1 and reset: n=1, input 300 -> acc_data=300 one cycle later. Reset asserted after 2 of 4 sums in n=4 -> after release, sums 1,1,1,1 give 4.
- Saturation (acc_width=10, ACCUM_SATURATE_EN defined): four sums of 500 -> 1023. Macro undefined -> 2000 mod 1024 = 976.

Source files
------------

// File: rtl/sum_accumulator_with_flow_control.sv
// sum_accumulator_with_flow_control
//
// Adds up groups of n consecutive sums taken from a valid/ready input
// stream. Each group total goes out on a valid/ready output. A running
// accumulator and a held result register give double buffering, so the
// input stalls only when a group completes while the previous total is
// still waiting to be accepted.
//
// Ports:
//   clk       clock, rising edge
//   rst       synchronous active-high reset
//   sum_vld   upstream sum valid
//   sum_rdy   upstream ready (combinational from acc_rdy only)
//   sum_data  upstream sum, width+1 bits, unsigned
//   acc_vld   group total valid
//   acc_rdy   downstream ready
//   acc_data  group total, acc_width bits, unsigned
//   acc_cnt   sums accepted into the group in progress (0..n-1)
//
// Optional feature, macro ACCUM_SATURATE_EN:
//   defined   - each addition carries one extra bit; a carry-out clamps the
//               accumulator/result to all-ones, sticky until the group ends
//   undefined - additions wrap modulo 2^acc_width

module sum_accumulator_with_flow_control #(
    parameter int unsigned width     = 8,
    parameter int unsigned n         = 4,
    parameter int unsigned acc_width = width + 1 + $clog2(n)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 sum_vld,
    output logic                 sum_rdy,
    input  logic [width:0]       sum_data,
    output logic                 acc_vld,
    input  logic                 acc_rdy,
    output logic [acc_width-1:0] acc_data,
    output logic [$clog2(n):0]   acc_cnt
);

    localparam int unsigned     CntW    = $clog2(n) + 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(n - 1);

    logic [acc_width-1:0] r_acc;
    logic [acc_width-1:0] r_res;
    logic [CntW-1:0]      r_cnt;
    logic                 r_vld;

    logic                 w_last;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [acc_width-1:0] w_next;

    assign w_last     = (r_cnt == LastCnt);
    // Only block the input when the completing sum has nowhere to go.
    assign sum_rdy    = ~(r_vld & ~acc_rdy & w_last);
    assign w_in_fire  = sum_vld & sum_rdy;
    assign w_out_fire = r_vld & acc_rdy;

`ifdef ACCUM_SATURATE_EN
    logic [acc_width:0] w_add;
    logic               w_sat;
    logic               r_sat;

    always_comb begin
        w_add  = (acc_width + 1)'(r_acc) + (acc_width + 1)'(sum_data);
        // Once clamped, the group stays clamped.
        w_sat  = w_add[acc_width] | r_sat;
        w_next = w_sat ? '1 : w_add[acc_width-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat <= 1'b0;
        end else if (w_in_fire) begin
            r_sat <= w_last ? 1'b0 : w_sat;
        end
    end
`else
    logic [acc_width-1:0] w_add;

    always_comb begin
        w_add  = r_acc + acc_width'(sum_data);
        w_next = w_add;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_res <= '0;
            r_vld <= 1'b0;
        end else begin
            if (w_in_fire) begin
                if (w_last) begin
                    r_res <= w_next;
                    r_acc <= '0;
                    r_cnt <= '0;
                end else begin
                    r_acc <= w_next;
                    r_cnt <= r_cnt + CntW'(1);
                end
            end
            // A completing input wins over an output transfer in the same
            // cycle, so back-to-back totals keep acc_vld high.
            if (w_in_fire && w_last) begin
                r_vld <= 1'b1;
            end else if (w_out_fire) begin
                r_vld <= 1'b0;
            end
        end
    end

    assign acc_vld  = r_vld;
    assign acc_data = r_res;
    assign acc_cnt  = r_cnt;

endmodule

// File: tb/tb_sum_accumulator_with_flow_control.sv
module tb_sum_accumulator_with_flow_control;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Main instance: width=8, n=4, acc_width=11
    logic        sum_vld = 1'b0;
    logic        sum_rdy;
    logic [8:0]  sum_data = '0;
    logic        acc_vld;
    logic        acc_rdy = 1'b1;
    logic [10:0] acc_data;
    logic [2:0]  acc_cnt;

    // n=1 instance: acc_width=9
    logic        s1_vld = 1'b0;
    logic        s1_rdy;
    logic [8:0]  s1_data = '0;
    logic        a1_vld;
    logic        a1_rdy = 1'b1;
    logic [8:0]  a1_data;
    logic [0:0]  a1_cnt;

    // Narrow-accumulator instance: n=4, acc_width=10
    logic        ss_vld = 1'b0;
    logic        ss_rdy;
    logic [8:0]  ss_data = '0;
    logic        as_vld;
    logic        as_rdy = 1'b1;
    logic [9:0]  as_data;
    logic [2:0]  as_cnt;

    sum_accumulator_with_flow_control #(.width(8), .n(4)) u_main (
        .clk(clk), .rst(rst), .sum_vld(sum_vld), .sum_rdy(sum_rdy), .sum_data(sum_data),
        .acc_vld(acc_vld), .acc_rdy(acc_rdy), .acc_data(acc_data), .acc_cnt(acc_cnt)
    );

    sum_accumulator_with_flow_control #(.width(8), .n(1)) u_n1 (
        .clk(clk), .rst(rst), .sum_vld(s1_vld), .sum_rdy(s1_rdy), .sum_data(s1_data),
        .acc_vld(a1_vld), .acc_rdy(a1_rdy), .acc_data(a1_data), .acc_cnt(a1_cnt)
    );

    sum_accumulator_with_flow_control #(.width(8), .n(4), .acc_width(10)) u_sat (
        .clk(clk), .rst(rst), .sum_vld(ss_vld), .sum_rdy(ss_rdy), .sum_data(ss_data),
        .acc_vld(as_vld), .acc_rdy(as_rdy), .acc_data(as_data), .acc_cnt(as_cnt)
    );

    int n_err = 0;
    int n_chk = 0;
    int cyc = 0;
    int stall_cnt = 0;

    int q_main[$];
    int q_n1[$];
    int q_sat[$];
    int pop_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Scoreboard monitor: one expected total popped per output transfer.
    always @(negedge clk) begin
        if (acc_vld && acc_rdy) begin
            if (q_main.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL main_unexpected: got %0d expected no output", acc_data);
            end else begin
                chk("main_total", 32'(acc_data), 32'(q_main.pop_front()));
                pop_cyc.push_back(cyc);
            end
        end
        if (a1_vld && a1_rdy) begin
            if (q_n1.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL n1_unexpected: got %0d expected no output", a1_data);
            end else begin
                chk("n1_total", 32'(a1_data), 32'(q_n1.pop_front()));
            end
        end
        if (as_vld && as_rdy) begin
            if (q_sat.size() == 0) begin
                n_chk++;
                n_err++;
                $display("FAIL sat_unexpected: got %0d expected no output", as_data);
            end else begin
                chk("sat_total", 32'(as_data), 32'(q_sat.pop_front()));
            end
        end
    end

    // Present one sum on the main instance; returns at posedge+1 after it transfers.
    task automatic send(input logic [8:0] d);
        sum_vld  = 1'b1;
        sum_data = d;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (sum_rdy) begin
                @(posedge clk);
                #1;
                sum_vld = 1'b0;
                return;
            end
            stall_cnt++;
            @(posedge clk);
            #1;
        end
        n_chk++;
        n_err++;
        $display("FAIL send_timeout: got no transfer expected transfer of %0d", d);
        sum_vld = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    logic [31:0] sat_exp;
    logic        bub_v[8]   = '{1, 0, 1, 0, 0, 1, 1, 0};
    int          bub_cnt[8] = '{0, 1, 1, 2, 2, 2, 3, 0};

    initial begin
`ifdef ACCUM_SATURATE_EN
        sat_exp = 32'd1023;
`else
        sat_exp = 32'd976;
`endif
        // Reset state
        tick();
        tick();
        chk("rst_acc_vld", 32'(acc_vld), 32'd0);
        chk("rst_acc_cnt", 32'(acc_cnt), 32'd0);
        chk("rst_acc_data", 32'(acc_data), 32'd0);
        chk("rst_sum_rdy", 32'(sum_rdy), 32'd1);
        rst = 1'b0;
        tick();

        // Basic group 1,2,3,4 -> 10, valid for exactly one cycle
        q_main.push_back(10);
        send(9'd1);
        send(9'd2);
        send(9'd3);
        send(9'd4);
        @(negedge clk);
        chk("basic_vld", 32'(acc_vld), 32'd1);
        chk("basic_data", 32'(acc_data), 32'd10);
        @(negedge clk);
        chk("basic_vld_drop", 32'(acc_vld), 32'd0);
        tick();

        // Back-to-back: 8 x 510 -> 2040, 2040, four cycles apart
        pop_cyc.delete();
        stall_cnt = 0;
        q_main.push_back(2040);
        q_main.push_back(2040);
        for (int i = 0; i < 8; i++) send(9'd510);
        @(negedge clk);
        tick();
        chk("b2b_no_stall", 32'(stall_cnt), 32'd0);
        chk("b2b_pops", 32'(pop_cyc.size()), 32'd2);
        if (pop_cyc.size() == 2) chk("b2b_spacing", 32'(pop_cyc[1] - pop_cyc[0]), 32'd4);

        // Output stall
        acc_rdy = 1'b0;
        q_main.push_back(10);
        q_main.push_back(20);
        send(9'd1);
        send(9'd2);
        send(9'd3);
        send(9'd4);
        stall_cnt = 0;
        send(9'd5);
        send(9'd5);
        send(9'd5);
        chk("stall_first3", 32'(stall_cnt), 32'd0);
        sum_vld  = 1'b1;
        sum_data = 9'd5;
        @(negedge clk);
        chk("stall_rdy_low", 32'(sum_rdy), 32'd0);
        chk("stall_vld", 32'(acc_vld), 32'd1);
        chk("stall_hold1", 32'(acc_data), 32'd10);
        tick();
        @(negedge clk);
        chk("stall_hold2", 32'(acc_data), 32'd10);
        chk("stall_cnt3", 32'(acc_cnt), 32'd3);
        tick();
        acc_rdy = 1'b1;
        @(negedge clk);
        chk("stall_rdy_back", 32'(sum_rdy), 32'd1);
        tick();
        sum_vld = 1'b0;
        @(negedge clk);
        chk("stall_cnt0", 32'(acc_cnt), 32'd0);
        tick();

        // Bubbles: single total 28 with the acc_cnt trace below
        q_main.push_back(28);
        for (int i = 0; i < 8; i++) begin
            sum_vld  = bub_v[i];
            sum_data = 9'd7;
            @(negedge clk);
            chk($sformatf("bub_cnt%0d", i), 32'(acc_cnt), 32'(bub_cnt[i]));
            tick();
        end
        sum_vld = 1'b0;
        tick();

        // Reset discards a pending total and a partial group
        acc_rdy = 1'b0;
        send(9'd1);
        send(9'd2);
        send(9'd3);
        send(9'd4);
        send(9'd1);
        send(9'd1);
        rst = 1'b1;
        tick();
        chk("mid_rst_vld", 32'(acc_vld), 32'd0);
        chk("mid_rst_cnt", 32'(acc_cnt), 32'd0);
        chk("mid_rst_rdy", 32'(sum_rdy), 32'd1);
        rst     = 1'b0;
        acc_rdy = 1'b1;
        tick();
        q_main.push_back(4);
        for (int i = 0; i < 4; i++) send(9'd1);
        tick();
        tick();

        // n=1: register slice behaviour
        q_n1.push_back(300);
        q_n1.push_back(5);
        s1_vld  = 1'b1;
        s1_data = 9'd300;
        @(negedge clk);
        chk("n1_rdy", 32'(s1_rdy), 32'd1);
        tick();
        chk("n1_latency_vld", 32'(a1_vld), 32'd1);
        chk("n1_latency_data", 32'(a1_data), 32'd300);
        s1_data = 9'd5;
        tick();
        s1_vld = 1'b0;
        tick();
        tick();

        // Narrow accumulator: 4 x 500 into 10 bits
        q_sat.push_back(int'(sat_exp));
        ss_vld  = 1'b1;
        ss_data = 9'd500;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("sat_rdy%0d", i), 32'(ss_rdy), 32'd1);
            tick();
        end
        ss_vld = 1'b0;
        tick();
        tick();

        chk("main_queue_empty", 32'(q_main.size()), 32'd0);
        chk("n1_queue_empty", 32'(q_n1.size()), 32'd0);
        chk("sat_queue_empty", 32'(q_sat.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
